// File: rtl/fb_scanout_pkg.sv
// Shared types and default VGA 640x480 timing for the framebuffer scanout block.
package fb_scanout_pkg;

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        MUTED   = 2'd2
    } scan_state_t;

    localparam int unsigned VGA_H_ACTIVE = 640;
    localparam int unsigned VGA_H_FRONT  = 16;
    localparam int unsigned VGA_H_SYNC   = 96;
    localparam int unsigned VGA_H_BACK   = 48;
    localparam int unsigned VGA_V_ACTIVE = 480;
    localparam int unsigned VGA_V_FRONT  = 10;
    localparam int unsigned VGA_V_SYNC   = 2;
    localparam int unsigned VGA_V_BACK   = 33;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_timing.sv
// Raster h/v counters with position-level data-enable, active-low syncs and frame-boundary strobe.
module video_timing
    import fb_scanout_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA_H_FRONT,
    parameter int unsigned H_SYNC   = VGA_H_SYNC,
    parameter int unsigned H_BACK   = VGA_H_BACK,
    parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA_V_FRONT,
    parameter int unsigned V_SYNC   = VGA_V_SYNC,
    parameter int unsigned V_BACK   = VGA_V_BACK,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK,
    localparam int unsigned HW      = cnt_width(H_TOTAL),
    localparam int unsigned VW      = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          de,
    output logic          hsync,
    output logic          vsync,
    output logic          boundary
);

    logic h_last;
    logic v_last;

    assign h_last = (h == HW'(H_TOTAL - 1));
    assign v_last = (v == VW'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (!run) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    always_comb begin
        de       = run && (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
        hsync    = !(run && (h >= HW'(H_ACTIVE + H_FRONT))
                         && (h <  HW'(H_ACTIVE + H_FRONT + H_SYNC)));
        vsync    = !(run && (v >= VW'(V_ACTIVE + V_FRONT))
                         && (v <  VW'(V_ACTIVE + V_FRONT + V_SYNC)));
        boundary = run && h_last && v_last;
    end

endmodule

// File: rtl/framebuffer_scanout.sv
// Scans the framebuffer in raster order with integer upscaling and emits a timed video stream.
// Holds the run/mute FSM, the multiplier-free address generator and the output alignment pipeline.
module framebuffer_scanout
    import fb_scanout_pkg::*;
#(
    parameter int unsigned FB_WIDTH   = 160,
    parameter int unsigned FB_HEIGHT  = 120,
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned SCALE      = 4,
    parameter int unsigned H_FRONT    = VGA_H_FRONT,
    parameter int unsigned H_SYNC     = VGA_H_SYNC,
    parameter int unsigned H_BACK     = VGA_H_BACK,
    parameter int unsigned V_FRONT    = VGA_V_FRONT,
    parameter int unsigned V_SYNC     = VGA_V_SYNC,
    parameter int unsigned V_BACK     = VGA_V_BACK,
    parameter logic [DATA_WIDTH-1:0] BLANK_VALUE = '0,
    localparam int unsigned ADDR_WIDTH = cnt_width(FB_WIDTH * FB_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fb_ready,
    output logic [ADDR_WIDTH-1:0] fb_addr_read,
    input  logic [DATA_WIDTH-1:0] fb_data,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  de_out,
    output logic                  hsync_out,
    output logic                  vsync_out,
    output logic                  frame_start,
    output logic                  frame_end
);

    localparam int unsigned H_ACTIVE = FB_WIDTH * SCALE;
    localparam int unsigned V_ACTIVE = FB_HEIGHT * SCALE;
    localparam int unsigned HW = cnt_width(H_ACTIVE + H_FRONT + H_SYNC + H_BACK);
    localparam int unsigned VW = cnt_width(V_ACTIVE + V_FRONT + V_SYNC + V_BACK);
    localparam int unsigned SW = cnt_width(SCALE);
    localparam int unsigned XW = cnt_width(FB_WIDTH);

    scan_state_t state, state_next;
    logic run, show;

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    logic de_pos, hsync_pos, vsync_pos, boundary;

    video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) u_timing (
        .clk      (clk),
        .rst_n    (rst_n),
        .run      (run),
        .h        (h),
        .v        (v),
        .de       (de_pos),
        .hsync    (hsync_pos),
        .vsync    (vsync_pos),
        .boundary (boundary)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= STOPPED;
        else        state <= state_next;
    end

    // Mode only changes at a frame boundary so a frame is never half blanked.
    always_comb begin
        state_next = state;
        case (state)
            STOPPED: if (enable) state_next = fb_ready ? RUNNING : MUTED;
            RUNNING,
            MUTED:   if (boundary) state_next = !enable ? STOPPED : (fb_ready ? RUNNING : MUTED);
            default: state_next = STOPPED;
        endcase
    end

    always_comb begin
        run  = (state != STOPPED);
        show = (state == RUNNING);
    end

    logic [SW-1:0]         col_sub, row_sub;
    logic [XW-1:0]         fb_x;
    logic [ADDR_WIDTH-1:0] row_base;
    logic                  line_last;

    assign line_last = de_pos && (h == HW'(H_ACTIVE - 1));

    // Sub-counters replace (v/SCALE)*FB_WIDTH + h/SCALE; fb_x wraps naturally at line end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_sub  <= '0;
            row_sub  <= '0;
            fb_x     <= '0;
            row_base <= '0;
        end else if (!run || boundary) begin
            col_sub  <= '0;
            row_sub  <= '0;
            fb_x     <= '0;
            row_base <= '0;
        end else if (de_pos) begin
            if (col_sub == SW'(SCALE - 1)) begin
                col_sub <= '0;
                fb_x    <= (fb_x == XW'(FB_WIDTH - 1)) ? '0 : fb_x + XW'(1);
            end else begin
                col_sub <= col_sub + SW'(1);
            end
            if (line_last) begin
                if (row_sub == SW'(SCALE - 1)) begin
                    row_sub  <= '0;
                    row_base <= row_base + ADDR_WIDTH'(FB_WIDTH);
                end else begin
                    row_sub <= row_sub + SW'(1);
                end
            end
        end
    end

    logic first_pos, last_pos;
    assign first_pos = show && de_pos && (h == '0) && (v == '0);
    assign last_pos  = show && line_last && (v == VW'(V_ACTIVE - 1));

    logic de1, hs1, vs1, fs1, fe1, show1;
    logic de2, hs2, vs2, fs2, show2;

    // Stage 1 issues the read; stage 2 waits on the framebuffer; stage 3 registers the pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_addr_read <= '0;
            de1 <= 1'b0; hs1 <= 1'b1; vs1 <= 1'b1; fs1 <= 1'b0; fe1 <= 1'b0; show1 <= 1'b0;
            de2 <= 1'b0; hs2 <= 1'b1; vs2 <= 1'b1; fs2 <= 1'b0; show2 <= 1'b0;
            frame_end   <= 1'b0;
            pixel_out   <= BLANK_VALUE;
            de_out      <= 1'b0;
            hsync_out   <= 1'b1;
            vsync_out   <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            fb_addr_read <= de_pos ? row_base + ADDR_WIDTH'(fb_x) : '0;
            de1   <= de_pos;
            hs1   <= hsync_pos;
            vs1   <= vsync_pos;
            fs1   <= first_pos;
            fe1   <= last_pos;
            show1 <= show && de_pos;

            de2   <= de1;
            hs2   <= hs1;
            vs2   <= vs1;
            fs2   <= fs1;
            show2 <= show1;
            frame_end <= fe1;

            pixel_out   <= show2 ? fb_data : BLANK_VALUE;
            de_out      <= de2;
            hsync_out   <= hs2;
            vsync_out   <= vs2;
            frame_start <= fs2;
        end
    end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Self-checking bench: small 4x2 framebuffer, SCALE 2, compared cycle by cycle with a raster-level model.
module tb_framebuffer_scanout;

    localparam int FBW = 4, FBH = 2, SC = 2, DW = 12, AW = 3;
    localparam int HF = 1, HS = 2, HB = 1, VF = 1, VS = 1, VB = 1;
    localparam int HA = FBW * SC, VA = FBH * SC;
    localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0, fb_ready = 1'b0;
    logic [AW-1:0] fb_addr_read;
    logic [DW-1:0] fb_data, pixel_out;
    logic de_out, hsync_out, vsync_out, frame_start, frame_end;

    logic [DW-1:0] mem [FBW*FBH];
    int unsigned n_checks = 0, n_fail = 0;

    framebuffer_scanout #(
        .FB_WIDTH(FBW), .FB_HEIGHT(FBH), .DATA_WIDTH(DW), .SCALE(SC),
        .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .BLANK_VALUE(12'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .fb_ready(fb_ready),
        .fb_addr_read(fb_addr_read), .fb_data(fb_data), .pixel_out(pixel_out),
        .de_out(de_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .frame_start(frame_start), .frame_end(frame_end)
    );

    always #5 clk = ~clk;
    always @(posedge clk) fb_data <= mem[fb_addr_read];

    // ---------------- reference model ----------------
    typedef enum int {M_STOP, M_RUN, M_MUTE} mstate_t;
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] pix;
        logic de, hs, vs, fs, fe;
    } obs_t;

    localparam obs_t RESET_OBS = '{addr: '0, pix: '0, de: 1'b0, hs: 1'b1, vs: 1'b1, fs: 1'b0, fe: 1'b0};

    mstate_t m_st;
    int m_h, m_v;
    obs_t e1, e2, e3;

    function automatic obs_t position_out(mstate_t st, int h, int v);
        obs_t o;
        bit on, act;
        int idx;
        o = '0;
        on  = (st != M_STOP);
        act = on && h < HA && v < VA;
        if (act) begin
            idx = (v / SC) * FBW + h / SC;
            o.addr = AW'(idx);
            if (st == M_RUN) o.pix = mem[idx];
        end
        o.de = act;
        o.hs = !(on && h >= HA + HF && h < HA + HF + HS);
        o.vs = !(on && v >= VA + VF && v < VA + VF + VS);
        o.fs = (st == M_RUN) && h == 0 && v == 0;
        o.fe = (st == M_RUN) && h == HA - 1 && v == VA - 1;
        return o;
    endfunction

    task automatic model_reset();
        m_st = M_STOP; m_h = 0; m_v = 0;
        e1 = position_out(M_STOP, 0, 0);
        e2 = e1;
        e3 = e1;
    endtask

    task automatic model_step();
        obs_t p;
        if (!rst_n) begin
            model_reset();
        end else begin
            p = position_out(m_st, m_h, m_v);
            e3 = e2; e2 = e1; e1 = p;
            if (m_st == M_STOP) begin
                if (enable) m_st = fb_ready ? M_RUN : M_MUTE;
            end else if (m_h == HT - 1 && m_v == VT - 1) begin
                m_h = 0; m_v = 0;
                m_st = !enable ? M_STOP : (fb_ready ? M_RUN : M_MUTE);
            end else if (m_h == HT - 1) begin
                m_h = 0; m_v = m_v + 1;
            end else begin
                m_h = m_h + 1;
            end
        end
    endtask

    function automatic obs_t expected();
        obs_t o;
        o = e3;
        o.addr = e1.addr;
        o.fe = e2.fe;
        return o;
    endfunction

    function automatic obs_t observed();
        return '{addr: fb_addr_read, pix: pixel_out, de: de_out, hs: hsync_out,
                 vs: vsync_out, fs: frame_start, fe: frame_end};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; fb_ready = 1'b0;
        model_reset();
        repeat (3) tick();
        n_checks++;
        if (observed() !== RESET_OBS) begin
            n_fail++; $display("FAIL reset_values got %h expected %h", observed(), RESET_OBS);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL stopped_idle cyc %0d got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_running();
        int fs_at, win, fs_cnt, fe_cnt, de_cnt, hlow, vlow;
        fs_at = -1; win = -1; fs_cnt = 0; fe_cnt = 0; de_cnt = 0; hlow = 0; vlow = 0;
        @(negedge clk) begin enable = 1'b1; fb_ready = 1'b1; end
        for (int i = 1; i <= 2 * FRAME + 10; i++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL running cyc %0d got %h expected %h", i, observed(), expected());
            end
            if (fs_at < 0 && frame_start) begin fs_at = i; win = 0; end
            if (win >= 0 && win < FRAME) begin
                fs_cnt += int'(frame_start); fe_cnt += int'(frame_end); de_cnt += int'(de_out);
                hlow += int'(!hsync_out); vlow += int'(!vsync_out);
                if (win < HA) begin
                    n_checks++;
                    if (pixel_out !== mem[win / SC] || de_out !== 1'b1) begin
                        n_fail++; $display("FAIL line0_pixel %0d got %h/%b expected %h/1", win, pixel_out, de_out, mem[win / SC]);
                    end
                end
                win++;
            end
        end
        n_checks++; if (fs_at !== 4) begin n_fail++; $display("FAIL first_pixel_latency got %0d expected 4", fs_at); end
        n_checks++; if (fs_cnt !== 1) begin n_fail++; $display("FAIL frame_start_count got %0d expected 1", fs_cnt); end
        n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL frame_end_count got %0d expected 1", fe_cnt); end
        n_checks++; if (de_cnt !== HA * VA) begin n_fail++; $display("FAIL de_count got %0d expected %0d", de_cnt, HA * VA); end
        n_checks++; if (hlow !== HS * VT) begin n_fail++; $display("FAIL hsync_low got %0d expected %0d", hlow, HS * VT); end
        n_checks++; if (vlow !== VS * HT) begin n_fail++; $display("FAIL vsync_low got %0d expected %0d", vlow, VS * HT); end
    endtask

    task automatic wait_frame_start(input string tag);
        int k;
        k = 0;
        while (!frame_start && k < 3 * FRAME) begin tick(); k++; end
        n_checks++;
        if (!frame_start) begin n_fail++; $display("FAIL %s frame_start timeout got 0 expected 1", tag); end
    endtask

    task automatic test_muted();
        int mfs, mfe, mde, mpx, fs_i;
        mfs = 0; mfe = 0; mde = 0; mpx = 0; fs_i = -1;
        wait_frame_start("muted");
        for (int i = 1; i <= 2 * FRAME + 10; i++) begin
            @(negedge clk) fb_ready = (i >= 100);
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL muted cyc %0d got %h expected %h", i, observed(), expected());
            end
            if (i >= FRAME && i < 2 * FRAME) begin
                mfs += int'(frame_start); mfe += int'(frame_end);
                mde += int'(de_out); mpx += int'(pixel_out != '0);
            end
            if (fs_i < 0 && i >= FRAME && frame_start) fs_i = i;
        end
        n_checks++; if (mfs + mfe !== 0) begin n_fail++; $display("FAIL muted_pulses got %0d expected 0", mfs + mfe); end
        n_checks++; if (mde !== HA * VA) begin n_fail++; $display("FAIL muted_de got %0d expected %0d", mde, HA * VA); end
        n_checks++; if (mpx !== 0) begin n_fail++; $display("FAIL muted_pixels got %0d expected 0", mpx); end
        n_checks++; if (fs_i !== 2 * FRAME) begin n_fail++; $display("FAIL resume_running got %0d expected %0d", fs_i, 2 * FRAME); end
    endtask

    task automatic test_ready_glitch();
        int gs, gl, fs_i, fe_cnt;
        gs = $urandom_range(10, 60); gl = $urandom_range(1, 4); fs_i = -1; fe_cnt = 0;
        wait_frame_start("glitch");
        for (int i = 1; i <= FRAME + 10; i++) begin
            @(negedge clk) fb_ready = !(i >= gs && i < gs + gl);
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL ready_glitch cyc %0d got %h expected %h", i, observed(), expected());
            end
            fe_cnt += int'(frame_end);
            if (fs_i < 0 && frame_start) fs_i = i;
        end
        n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL glitch_frame_end got %0d expected 1", fe_cnt); end
        n_checks++; if (fs_i !== FRAME) begin n_fail++; $display("FAIL glitch_next_frame got %0d expected %0d", fs_i, FRAME); end
    endtask

    task automatic test_enable_toggle();
        int fs_i;
        fs_i = -1;
        wait_frame_start("toggle");
        for (int i = 1; i <= FRAME + 10; i++) begin
            @(negedge clk) enable = !(i >= 10 && i < 30);
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL enable_toggle cyc %0d got %h expected %h", i, observed(), expected());
            end
            if (fs_i < 0 && frame_start) fs_i = i;
        end
        n_checks++; if (fs_i !== FRAME) begin n_fail++; $display("FAIL toggle_no_effect got %0d expected %0d", fs_i, FRAME); end
    endtask

    task automatic test_enable_stop();
        int fe_cnt, de_cnt, busy;
        fe_cnt = 0; de_cnt = 0; busy = 0;
        wait_frame_start("stop");
        for (int i = 1; i <= FRAME + 40; i++) begin
            @(negedge clk) enable = (i < 20);
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL enable_stop cyc %0d got %h expected %h", i, observed(), expected());
            end
            fe_cnt += int'(frame_end);
            if (i < FRAME) de_cnt += int'(de_out);
            if (i >= FRAME && observed() !== RESET_OBS) busy++;
        end
        n_checks++; if (fe_cnt !== 1) begin n_fail++; $display("FAIL stop_frame_end got %0d expected 1", fe_cnt); end
        n_checks++; if (de_cnt !== HA * VA - 1) begin n_fail++; $display("FAIL stop_frame_completes got %0d expected %0d", de_cnt, HA * VA - 1); end
        n_checks++; if (busy !== 0) begin n_fail++; $display("FAIL stopped_outputs got %0d busy cycles expected 0", busy); end
    endtask

    task automatic test_reset_midline();
        int fs_i;
        fs_i = -1;
        @(negedge clk) begin enable = 1'b1; fb_ready = 1'b1; end
        wait_frame_start("midline");
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (observed() !== RESET_OBS) begin
            n_fail++; $display("FAIL async_reset got %h expected %h", observed(), RESET_OBS);
        end
        model_reset();
        repeat (2) tick();
        @(negedge clk) rst_n = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL reset_restart cyc %0d got %h expected %h", i, observed(), expected());
            end
            if (fs_i < 0 && frame_start) fs_i = i;
        end
        n_checks++; if (fs_i !== 4) begin n_fail++; $display("FAIL restart_origin got %0d expected 4", fs_i); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk) begin
                enable   = ($urandom_range(0, 99) < 93);
                fb_ready = ($urandom_range(0, 99) < 70);
            end
            tick();
            n_checks++;
            if (observed() !== expected()) begin
                n_fail++; $display("FAIL random cyc %0d got %h expected %h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < FBW * FBH; i++) mem[i] = DW'($urandom_range(1, 4095));
        test_reset();
        test_running();
        test_muted();
        test_ready_glitch();
        test_enable_toggle();
        test_enable_stop();
        test_reset_midline();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
